// File: rtl/vc_flit_fifo.sv
// Multi-VC flit FIFO: NUM_VC independent queues sharing one storage array addressed {vc, ptr}.
// Define VC_FLIT_FIFO_ERR_EN to enable sticky overflow/underflow flags; otherwise they are tied low.
module vc_flit_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_VC     = 2,
  parameter int VC_WIDTH   = 1,
  parameter int AF_MARGIN  = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic [VC_WIDTH-1:0]                wr_vc,
  input  logic [DATA_WIDTH-1:0]              din,
  input  logic                               rd_en,
  input  logic [VC_WIDTH-1:0]                rd_vc,
  output logic [DATA_WIDTH-1:0]              dout,
  output logic                               dout_valid,
  output logic [VC_WIDTH-1:0]                dout_vc,
  output logic [NUM_VC-1:0]                  empty,
  output logic [NUM_VC-1:0]                  full,
  output logic [NUM_VC-1:0]                  almost_full,
  output logic [NUM_VC*(ADDR_WIDTH+1)-1:0]   count,
  output logic                               ovf_err,
  output logic                               udf_err
);
  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int MEM_AW = VC_WIDTH + ADDR_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [31:0]      AF_MARGIN_C = 32'(AF_MARGIN);

  logic [DATA_WIDTH-1:0] mem [NUM_VC*DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q [NUM_VC];
  logic [ADDR_WIDTH-1:0] wr_ptr_d [NUM_VC];
  logic [ADDR_WIDTH-1:0] rd_ptr_q [NUM_VC];
  logic [ADDR_WIDTH-1:0] rd_ptr_d [NUM_VC];
  logic [CNT_W-1:0]      count_q  [NUM_VC];
  logic [CNT_W-1:0]      count_d  [NUM_VC];

  logic [NUM_VC-1:0]     wr_hit;
  logic [NUM_VC-1:0]     rd_hit;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [ADDR_WIDTH-1:0] wr_ptr_sel;
  logic [ADDR_WIDTH-1:0] rd_ptr_sel;
  logic [MEM_AW-1:0]     wr_addr;
  logic [MEM_AW-1:0]     rd_addr;

  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_valid_q;
  logic                  dout_valid_d;
  logic [VC_WIDTH-1:0]   dout_vc_q;
  logic [VC_WIDTH-1:0]   dout_vc_d;

  // An out-of-range VC matches no lane, so it is rejected without extra checks.
  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
    logic [CNT_W-1:0] free_entries;
    assign rd_hit[gi] = rd_en && (rd_vc == VC_WIDTH'(gi)) && (count_q[gi] != '0);
    assign wr_hit[gi] = wr_en && (wr_vc == VC_WIDTH'(gi)) &&
                        ((count_q[gi] != DEPTH_C) || rd_hit[gi]);
    assign free_entries    = DEPTH_C - count_q[gi];
    assign empty[gi]       = (count_q[gi] == '0);
    assign full[gi]        = (count_q[gi] == DEPTH_C);
    assign almost_full[gi] = (32'(free_entries) <= AF_MARGIN_C);
    assign count[gi*CNT_W +: CNT_W] = count_q[gi];
  end

  assign wr_acc = |wr_hit;
  assign rd_acc = |rd_hit;

  always_comb begin
    wr_ptr_sel = '0;
    rd_ptr_sel = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (wr_vc == VC_WIDTH'(i)) wr_ptr_sel = wr_ptr_q[i];
      if (rd_vc == VC_WIDTH'(i)) rd_ptr_sel = rd_ptr_q[i];
    end
  end

  assign wr_addr = {wr_vc, wr_ptr_sel};
  assign rd_addr = {rd_vc, rd_ptr_sel};

  // Pointers wrap naturally at DEPTH; a simultaneous read and write leaves count unchanged.
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + ADDR_WIDTH'(wr_hit[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + ADDR_WIDTH'(rd_hit[i]);
      count_d[i]  = count_q[i] + CNT_W'(wr_hit[i]) - CNT_W'(rd_hit[i]);
    end
  end

  always_comb begin
    dout_valid_d = rd_acc;
    dout_vc_d    = rd_acc ? rd_vc : dout_vc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_vc_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      dout_valid_q <= dout_valid_d;
      dout_vc_q    <= dout_vc_d;
      if (rd_acc) dout_q <= mem[rd_addr];
    end
  end

  // Storage is not reset; read-before-write when a full VC is read and written together.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wr_addr] <= din;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_vc    = dout_vc_q;

`ifdef VC_FLIT_FIFO_ERR_EN
  logic ovf_q;
  logic ovf_d;
  logic udf_q;
  logic udf_d;

  always_comb begin
    ovf_d = ovf_q | (wr_en & ~wr_acc);
    udf_d = udf_q | (rd_en & ~rd_acc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
`else
  assign ovf_err = 1'b0;
  assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_vc_flit_fifo.sv
// Scoreboard bench for vc_flit_fifo: stimulus pushes expected {vc, flit}, a monitor pops on dout_valid.
`timescale 1ns/1ps
module tb_vc_flit_fifo;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NV = 2;
  localparam int VW = 1;
  localparam int CW = AW + 1;
`ifdef VC_FLIT_FIFO_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_en;
  logic [VW-1:0]   wr_vc;
  logic [DW-1:0]   din;
  logic            rd_en;
  logic [VW-1:0]   rd_vc;
  logic [DW-1:0]   dout;
  logic            dout_valid;
  logic [VW-1:0]   dout_vc;
  logic [NV-1:0]   empty;
  logic [NV-1:0]   full;
  logic [NV-1:0]   almost_full;
  logic [NV*CW-1:0] count;
  logic            ovf_err;
  logic            udf_err;

  always #5 clk = ~clk;

  vc_flit_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_VC(NV), .VC_WIDTH(VW), .AF_MARGIN(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_vc(wr_vc), .din(din),
    .rd_en(rd_en), .rd_vc(rd_vc),
    .dout(dout), .dout_valid(dout_valid), .dout_vc(dout_vc),
    .empty(empty), .full(full), .almost_full(almost_full), .count(count),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [VW+DW-1:0] exp_q[$];
  logic [VW+DW-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic push(input logic [VW-1:0] vc, input logic [DW-1:0] data);
    exp_q.push_back({vc, data});
  endtask

  function automatic logic [31:0] cnt(input int vc);
    return 32'(count[vc*CW +: CW]);
  endfunction

  // Monitor: every dout_valid must match the oldest expected read.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL dout_unexpected: got vc=%0d data=%h, required no dout_valid", dout_vc, dout);
      end else begin
        mon_e = exp_q.pop_front();
        if ({dout_vc, dout} !== mon_e) begin
          n_fail++;
          $display("FAIL dout: got vc=%0d data=%h, required vc=%0d data=%h",
                   dout_vc, dout, mon_e[VW+DW-1:DW], mon_e[DW-1:0]);
        end else begin
          $display("[TB] read vc=%0d data=%h", dout_vc, dout);
        end
      end
    end
  end

  int c;
  int r;

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_vc = '0; din = '0;
    rd_en = 1'b0; rd_vc = '0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_empty", 32'(empty), 32'h3);
    check("rst_full", 32'(full), 32'h0);
    check("rst_almost_full", 32'(almost_full), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_dout_valid", 32'(dout_valid), 32'h0);
    check("rst_dout", dout, 32'h0);
    check("rst_dout_vc", 32'(dout_vc), 32'h0);
    check("rst_ovf", 32'(ovf_err), 32'h0);
    check("rst_udf", 32'(udf_err), 32'h0);

    // Fill VC0 with 0x100..0x10F
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_vc = 1'b0; din = 32'h100 + 32'(i);
      step();
      check("fill_count0", cnt(0), 32'(i + 1));
      check("fill_af0", 32'(almost_full[0]), 32'((i + 1) >= 14));
    end
    idle();
    check("fill_full", 32'(full), 32'h1);
    check("fill_empty", 32'(empty), 32'h2);
    check("fill_count1", cnt(1), 32'h0);
    check("fill_ovf", 32'(ovf_err), 32'h0);

    // Overflow write is dropped
    wr_en = 1'b1; wr_vc = 1'b0; din = 32'hAAAA;
    step();
    idle();
    check("ovf_count0", cnt(0), 32'd16);
    check("ovf_flag", 32'(ovf_err), 32'(ERR_EXP));

    // Full VC0: simultaneous write and read both accepted
    wr_en = 1'b1; wr_vc = 1'b0; din = 32'hBEEF;
    rd_en = 1'b1; rd_vc = 1'b0;
    push(1'b0, 32'h100);
    step();
    idle();
    check("rw_full_count0", cnt(0), 32'd16);
    check("rw_full_full0", 32'(full[0]), 32'h1);
    check("rw_dout_valid", 32'(dout_valid), 32'h1);
    for (int i = 1; i < 16; i++) begin
      rd_en = 1'b1; rd_vc = 1'b0;
      push(1'b0, 32'h100 + 32'(i));
      step();
    end
    rd_en = 1'b1; rd_vc = 1'b0;
    push(1'b0, 32'hBEEF);
    step();
    idle();
    check("drain_count0", cnt(0), 32'h0);
    check("drain_empty", 32'(empty), 32'h3);
    step();
    check("idle_dout_valid", 32'(dout_valid), 32'h0);
    check("idle_dout_hold", dout, 32'hBEEF);

    // Interleaved VCs, plus a cross-VC write during a read
    wr_en = 1'b1; wr_vc = 1'b0; din = 32'h1; step();
    wr_en = 1'b1; wr_vc = 1'b1; din = 32'h2; step();
    wr_en = 1'b1; wr_vc = 1'b0; din = 32'h3; step();
    wr_en = 1'b0;
    check("ilv_count0", cnt(0), 32'd2);
    check("ilv_count1", cnt(1), 32'd1);
    rd_en = 1'b1; rd_vc = 1'b1; push(1'b1, 32'h2); step();
    rd_en = 1'b1; rd_vc = 1'b0; push(1'b0, 32'h1);
    wr_en = 1'b1; wr_vc = 1'b1; din = 32'h44; step();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_vc = 1'b0; push(1'b0, 32'h3); step();
    idle();
    check("ilv_after_count0", cnt(0), 32'h0);
    check("ilv_after_count1", cnt(1), 32'h1);
    rd_en = 1'b1; rd_vc = 1'b1; push(1'b1, 32'h44); step();
    idle();
    check("ilv_udf_clear", 32'(udf_err), 32'h0);

    // Read of empty VC1 with same-cycle write: no bypass
    rd_en = 1'b1; rd_vc = 1'b1;
    wr_en = 1'b1; wr_vc = 1'b1; din = 32'h55;
    step();
    idle();
    check("udf_dout_valid", 32'(dout_valid), 32'h0);
    check("udf_count1", cnt(1), 32'h1);
    check("udf_flag", 32'(udf_err), 32'(ERR_EXP));
    rd_en = 1'b1; rd_vc = 1'b1; push(1'b1, 32'h55); step();
    idle();

    // 40-flit stream on VC0 across pointer wrap
    c = 0;
    r = 0;
    for (int k = 0; k < 45; k++) begin
      wr_en = (k < 40); wr_vc = 1'b0; din = 32'h3000 + 32'(k);
      rd_en = (k >= 5); rd_vc = 1'b0;
      if (k >= 5) begin
        push(1'b0, 32'h3000 + 32'(r));
        r++;
      end
      c = c + ((k < 40) ? 1 : 0) - ((k >= 5) ? 1 : 0);
      step();
      check("stream_count0", cnt(0), 32'(c));
    end
    idle();

    // Partial stream, then reset together with a pending read
    wr_en = 1'b1; wr_vc = 1'b0; din = 32'hD1; step();
    wr_en = 1'b1; wr_vc = 1'b0; din = 32'hD2; step();
    wr_en = 1'b1; wr_vc = 1'b1; din = 32'hE1; step();
    idle();
    check("pre_rst_count0", cnt(0), 32'd2);
    check("pre_rst_ovf", 32'(ovf_err), 32'(ERR_EXP));
    check("pre_rst_udf", 32'(udf_err), 32'(ERR_EXP));
    rd_en = 1'b1; rd_vc = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    check("mid_rst_count", 32'(count), 32'h0);
    check("mid_rst_empty", 32'(empty), 32'h3);
    check("mid_rst_full", 32'(full), 32'h0);
    check("mid_rst_dout_valid", 32'(dout_valid), 32'h0);
    check("mid_rst_dout", dout, 32'h0);
    check("mid_rst_ovf", 32'(ovf_err), 32'h0);
    check("mid_rst_udf", 32'(udf_err), 32'h0);

    // Post-reset sanity on VC1: old 0xE1 must be gone
    wr_en = 1'b1; wr_vc = 1'b1; din = 32'h77; step();
    wr_en = 1'b0;
    check("post_rst_count1", cnt(1), 32'h1);
    rd_en = 1'b1; rd_vc = 1'b1; push(1'b1, 32'h77); step();
    idle();
    step();
    step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
